// File: rtl/dl_agc_gain_ramp_ctrl.sv
// Per-antenna gain scheduler for the downlink TDL AGC: captures dB-index targets on the
// frame head and walks the applied gains toward them in bounded, evenly spaced steps.
module dl_agc_gain_ramp_ctrl #(
  parameter int unsigned XNUM       = 8,
  parameter int unsigned RAMP_DIV   = 4,
  parameter int unsigned STEP       = 2,
  parameter logic [7:0]  RESET_GAIN = 8'd0
) (
  input  logic        clk_245,
  input  logic        asy_rst,
  input  logic        i_fram_hd,
  input  logic        i_ramp_en,
  input  logic [31:0] i_gain_tgt0,
  input  logic [31:0] i_gain_tgt1,
  input  logic [31:0] i_gain_tgt2,
  input  logic [31:0] i_gain_tgt3,
  input  logic [31:0] i_gain_tgt4,
  input  logic [31:0] i_gain_tgt5,
  input  logic [31:0] i_gain_tgt6,
  input  logic [31:0] i_gain_tgt7,
  output logic [31:0] o_lte_duc_gain0,
  output logic [31:0] o_lte_duc_gain1,
  output logic [31:0] o_lte_duc_gain2,
  output logic [31:0] o_lte_duc_gain3,
  output logic [31:0] o_lte_duc_gain4,
  output logic [31:0] o_lte_duc_gain5,
  output logic [31:0] o_lte_duc_gain6,
  output logic [31:0] o_lte_duc_gain7,
  output logic        o_busy,
  output logic        o_upd_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(RAMP_DIV - 1);
  localparam logic [8:0]  STEP9    = 9'(STEP);
  localparam logic [7:0]  STEP8    = 8'(STEP);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cur      [XNUM];
  logic [7:0]  tgt      [XNUM];
  logic [7:0]  tgt_in   [XNUM];
  logic [7:0]  cur_step [XNUM];
  logic [8:0]  up_diff  [XNUM];
  logic [8:0]  dn_diff  [XNUM];
  logic [15:0] div_cnt;
  logic        all_in_eq;
  logic        all_step_eq;
  logic        load_tgt;
  logic        load_now;
  logic        do_step;
  logic        div_clr;
  logic        unused_tgt_hi;

  // Only the low byte of each path register carries the dB index.
  assign tgt_in[0] = i_gain_tgt0[7:0];
  assign tgt_in[1] = i_gain_tgt1[7:0];
  assign tgt_in[2] = i_gain_tgt2[7:0];
  assign tgt_in[3] = i_gain_tgt3[7:0];
  assign tgt_in[4] = i_gain_tgt4[7:0];
  assign tgt_in[5] = i_gain_tgt5[7:0];
  assign tgt_in[6] = i_gain_tgt6[7:0];
  assign tgt_in[7] = i_gain_tgt7[7:0];
  assign unused_tgt_hi = ^{i_gain_tgt0[31:8], i_gain_tgt1[31:8], i_gain_tgt2[31:8],
                           i_gain_tgt3[31:8], i_gain_tgt4[31:8], i_gain_tgt5[31:8],
                           i_gain_tgt6[31:8], i_gain_tgt7[31:8]};

  // Candidate next gains: move by STEP, clamped to the remaining distance so nothing wraps.
  always_comb begin
    all_in_eq   = 1'b1;
    all_step_eq = 1'b1;
    for (int k = 0; k < XNUM; k++) begin
      up_diff[k] = {1'b0, tgt[k]} - {1'b0, cur[k]};
      dn_diff[k] = {1'b0, cur[k]} - {1'b0, tgt[k]};
      if (cur[k] < tgt[k]) begin
        cur_step[k] = cur[k] + ((up_diff[k] < STEP9) ? up_diff[k][7:0] : STEP8);
      end else if (cur[k] > tgt[k]) begin
        cur_step[k] = cur[k] - ((dn_diff[k] < STEP9) ? dn_diff[k][7:0] : STEP8);
      end else begin
        cur_step[k] = cur[k];
      end
      if (cur_step[k] != tgt[k]) begin
        all_step_eq = 1'b0;
      end else begin
        all_step_eq = all_step_eq;
      end
      if (tgt_in[k] != cur[k]) begin
        all_in_eq = 1'b0;
      end else begin
        all_in_eq = all_in_eq;
      end
    end
  end

  // Next-state decode; a frame head takes priority over a pending step in every state.
  always_comb begin
    state_nxt = state;
    load_tgt  = 1'b0;
    load_now  = 1'b0;
    do_step   = 1'b0;
    div_clr   = 1'b0;
    if (i_fram_hd) begin
      load_tgt = 1'b1;
      div_clr  = 1'b1;
      if (!i_ramp_en) begin
        load_now  = 1'b1;
        state_nxt = DONE;
      end else if (all_in_eq) begin
        state_nxt = DONE;
      end else begin
        state_nxt = RAMP;
      end
    end else begin
      case (state)
        RAMP: begin
          if (div_cnt == DIV_LAST) begin
            do_step   = 1'b1;
            state_nxt = all_step_eq ? DONE : RAMP;
          end else begin
            state_nxt = RAMP;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_245) begin
    if (asy_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Gain, target and step-divider registers.
  always_ff @(posedge clk_245) begin
    if (asy_rst) begin
      for (int k = 0; k < XNUM; k++) begin
        cur[k] <= RESET_GAIN;
        tgt[k] <= RESET_GAIN;
      end
      div_cnt <= 16'd0;
    end else begin
      for (int k = 0; k < XNUM; k++) begin
        if (load_tgt) begin
          tgt[k] <= tgt_in[k];
        end
        if (load_now) begin
          cur[k] <= tgt_in[k];
        end else if (do_step) begin
          cur[k] <= cur_step[k];
        end
      end
      if (div_clr || (state != RAMP) || (div_cnt == DIV_LAST)) begin
        div_cnt <= 16'd0;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

  assign o_busy     = (state == RAMP);
  assign o_upd_done = (state == DONE);

  assign o_lte_duc_gain0 = {24'd0, cur[0]};
  assign o_lte_duc_gain1 = {24'd0, cur[1]};
  assign o_lte_duc_gain2 = {24'd0, cur[2]};
  assign o_lte_duc_gain3 = {24'd0, cur[3]};
  assign o_lte_duc_gain4 = {24'd0, cur[4]};
  assign o_lte_duc_gain5 = {24'd0, cur[5]};
  assign o_lte_duc_gain6 = {24'd0, cur[6]};
  assign o_lte_duc_gain7 = {24'd0, cur[7]};

endmodule
